cpu_mem_axi_bridge: RTL and testbench
=====================================

# cpu_mem_axi_bridge
Converts the custom CPU's valid/ready data-memory port into single-beat AXI4 read and write transactions. It sits between the CPU core and the 2x1 CPU-to-memory AXI arbiter, and serves as the data-side counterpart of the instruction-fetch wrapper. At most one transaction is outstanding at a time. The MMIO/UART split stays outside this block and only gates its AW/W valids and ready/data returns.
## Interface
- No parameters; data path fixed at 32 bits, AXI address fixed at 40 bits.
- cpu_clk  in  1  sole clock; all state updates on rising edge
- cpu_reset  in  1  synchronous, active-high reset
- Address  in  32  CPU byte address, sampled at request acceptance
- MemWrite  in  1  CPU write request
- Write_data  in  32  store data, sampled at acceptance
- Write_strb  in  4  byte enables, sampled at acceptance
- MemRead  in  1  CPU read request
- Mem_Req_Ready  out  1  request accepted when (MemRead|MemWrite)&Mem_Req_Ready
- Read_data  out  32  load data; held stable while Read_data_Valid
- Read_data_Valid  out  1  load data available
- Read_data_Ready  in  1  CPU consumes load data
- cpu_mem_araddr  out  40  {8'h0, addr[31:2], 2'b00}
- cpu_mem_arvalid / cpu_mem_arready  out / in  1  AR handshake
- cpu_mem_rdata  in  32  read data
- cpu_mem_rvalid / cpu_mem_rready  in / out  1  R handshake
- cpu_mem_rlast  in  1  ignored; every burst is one beat
- cpu_mem_awaddr  out  40  {8'h0, addr[31:2], 2'b00}
- cpu_mem_awvalid / cpu_mem_awready  out / in  1  AW handshake
- cpu_mem_wdata / cpu_mem_wstrb  out  32 / 4  registered store data and strobes
- cpu_mem_wvalid / cpu_mem_wready  out / in  1  W handshake
- cpu_mem_wlast  out  1  equals cpu_mem_wvalid
- cpu_mem_bvalid / cpu_mem_bready  in / out  1  B handshake; response code not checked
- cpu_mem_arsize / cpu_mem_awsize  out  3  constant 3'b010
- cpu_mem_arburst / cpu_mem_awburst  out  2  constant 2'b01
- cpu_mem_arlen / cpu_mem_awlen  out  8  constant 8'h00
## Operation
- The FSM has six states: IDLE, WR (AW/W pending), WB (wait B), RA (AR pending), RR (wait R) and RD (present load data).
- IDLE: Mem_Req_Ready=1 and is decoded from state only.
  - On acceptance, register the address, data and strobes.
  - MemWrite goes to WR; MemRead goes to RA.
  - If both are asserted, the write wins and the read is dropped.
- WR: awvalid and wvalid both assert on entry.
  - Each valid drops independently after its own handshake, tracked by per-channel done flags.
  - The FSM moves to WB once both handshakes are done; this includes the case where both complete in the same cycle.
- WB: bready=1; on bvalid go to IDLE.
- RA: arvalid=1; on arready go to RR.
- RR: rready=1; on rvalid, capture rdata into the Read_data register and go to RD.
- RD: Read_data_Valid=1 until Read_data_Ready is seen, then go to IDLE.
- All AXI valids and readies are register-based or decoded from state. None depends combinationally on the CPU inputs.
## Timing
- Reset values:
  - State is IDLE and Mem_Req_Ready=1.
  - All AXI valids and readies and Read_data_Valid are 0.
  - Read_data, the addresses, wdata and wstrb are 0.
- Reset mid-transaction aborts it. All valids are low the cycle after reset, and no stale Read_data_Valid is produced afterwards.
- Write latency, acceptance at edge T with zero-wait slave:
  - AW and W valid during T+1.
  - bready during T+2.
  - Mem_Req_Ready high again in T+3.
- Read latency, same conditions:
  - arvalid during T+1.
  - rready during T+2.
  - Read_data_Valid during T+3.
  - Mem_Req_Ready high in T+4 if Read_data_Ready is held high.
- Slave stalls extend the corresponding state indefinitely. Addresses, wdata and wstrb stay stable while their valid is high.
- Mem_Req_Ready is 0 in every state except IDLE. A back-to-back request is accepted on the first IDLE cycle.
## Test plan
- Write 0x12345678, strb 4'hF, to 0x0000_1004 with a zero-wait slave:
  - awaddr is 40'h00_0000_1004 and wdata matches.
  - wlast=1 with wvalid.
  - Mem_Req_Ready returns after exactly 3 cycles.
- Read 0x0000_2002 where memory holds 0xDEADBEEF:
  - araddr is 40'h00_0000_2000.
  - Read_data=0xDEADBEEF with Read_data_Valid in T+3.
- Write with awready delayed 4 cycles and wready immediate:
  - wvalid drops after 1 cycle; awvalid is held 5 cycles.
  - bready asserts only after the AW handshake.
- Read with Read_data_Ready held low for 6 cycles:
  - Read_data_Valid and data stay stable throughout.
  - Mem_Req_Ready stays 0 until the cycle after Ready.
- Reset asserted while in RR:
  - rready=0 and Read_data_Valid=0 the next cycle.
  - The next read completes normally.
- MemRead and MemWrite asserted together: only the AW/W/B sequence occurs and arvalid never rises.

Source files
------------

// File: rtl/cpu_mem_axi_bridge.sv
// CPU valid/ready data-memory port to single-beat AXI4 read/write bridge.
// Ports: CPU request/response (Address, MemRead/MemWrite, Read_data*) and
// AXI4 master AR/R/AW/W/B channels (cpu_mem_*); one transaction in flight.
module cpu_mem_axi_bridge (
  input  logic        cpu_clk,
  input  logic        cpu_reset,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [39:0] cpu_mem_araddr,
  output logic        cpu_mem_arvalid,
  input  logic        cpu_mem_arready,
  input  logic [31:0] cpu_mem_rdata,
  input  logic        cpu_mem_rvalid,
  output logic        cpu_mem_rready,
  input  logic        cpu_mem_rlast,
  output logic [39:0] cpu_mem_awaddr,
  output logic        cpu_mem_awvalid,
  input  logic        cpu_mem_awready,
  output logic [31:0] cpu_mem_wdata,
  output logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_wvalid,
  input  logic        cpu_mem_wready,
  output logic        cpu_mem_wlast,
  input  logic        cpu_mem_bvalid,
  output logic        cpu_mem_bready,
  output logic [2:0]  cpu_mem_arsize,
  output logic [2:0]  cpu_mem_awsize,
  output logic [1:0]  cpu_mem_arburst,
  output logic [1:0]  cpu_mem_awburst,
  output logic [7:0]  cpu_mem_arlen,
  output logic [7:0]  cpu_mem_awlen
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_RA   = 3'd3;
  localparam logic [2:0] S_RR   = 3'd4;
  localparam logic [2:0] S_RD   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        aw_done, w_done;
  logic        unused_rlast;

  assign unused_rlast = cpu_mem_rlast;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    // A channel is done once its valid has dropped or handshakes now.
    aw_done   = ~awvalid_q | cpu_mem_awready;
    w_done    = ~wvalid_q | cpu_mem_wready;
    case (state_q)
      S_IDLE: begin
        if (MemWrite | MemRead) begin
          addr_d  = Address;
          wdata_d = Write_data;
          wstrb_d = Write_strb;
        end
        // Write has priority; a simultaneous read is dropped.
        if (MemWrite) begin
          state_d   = S_WR;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else if (MemRead) begin
          state_d = S_RA;
        end
      end
      S_WR: begin
        awvalid_d = awvalid_q & ~cpu_mem_awready;
        wvalid_d  = wvalid_q & ~cpu_mem_wready;
        if (aw_done & w_done) state_d = S_WB;
      end
      S_WB: if (cpu_mem_bvalid) state_d = S_IDLE;
      S_RA: if (cpu_mem_arready) state_d = S_RR;
      S_RR: begin
        if (cpu_mem_rvalid) begin
          rdata_d = cpu_mem_rdata;
          state_d = S_RD;
        end
      end
      S_RD: if (Read_data_Ready) state_d = S_IDLE;
      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end

  assign Mem_Req_Ready   = (state_q == S_IDLE);
  assign Read_data       = rdata_q;
  assign Read_data_Valid = (state_q == S_RD);

  assign cpu_mem_araddr  = {8'h00, addr_q[31:2], 2'b00};
  assign cpu_mem_awaddr  = {8'h00, addr_q[31:2], 2'b00};
  assign cpu_mem_arvalid = (state_q == S_RA);
  assign cpu_mem_rready  = (state_q == S_RR);
  assign cpu_mem_bready  = (state_q == S_WB);
  assign cpu_mem_awvalid = awvalid_q;
  assign cpu_mem_wvalid  = wvalid_q;
  assign cpu_mem_wlast   = wvalid_q;
  assign cpu_mem_wdata   = wdata_q;
  assign cpu_mem_wstrb   = wstrb_q;

  assign cpu_mem_arsize  = 3'b010;
  assign cpu_mem_awsize  = 3'b010;
  assign cpu_mem_arburst = 2'b01;
  assign cpu_mem_awburst = 2'b01;
  assign cpu_mem_arlen   = 8'h00;
  assign cpu_mem_awlen   = 8'h00;

endmodule

// File: tb/tb_cpu_mem_axi_bridge.sv
// Testbench for cpu_mem_axi_bridge: AXI slave with programmable latencies,
// CPU driver, and a word-level reference memory for load data.
module tb_cpu_mem_axi_bridge;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  logic [39:0] araddr, awaddr;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] rdata, wdata;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic [7:0]  arlen, awlen;

  int checks = 0;
  int failures = 0;

  always #5 cpu_clk = ~cpu_clk;

  cpu_mem_axi_bridge dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
    .Address(Address), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready),
    .cpu_mem_araddr(araddr), .cpu_mem_arvalid(arvalid),
    .cpu_mem_arready(arready), .cpu_mem_rdata(rdata),
    .cpu_mem_rvalid(rvalid), .cpu_mem_rready(rready),
    .cpu_mem_rlast(rlast), .cpu_mem_awaddr(awaddr),
    .cpu_mem_awvalid(awvalid), .cpu_mem_awready(awready),
    .cpu_mem_wdata(wdata), .cpu_mem_wstrb(wstrb),
    .cpu_mem_wvalid(wvalid), .cpu_mem_wready(wready),
    .cpu_mem_wlast(wlast), .cpu_mem_bvalid(bvalid),
    .cpu_mem_bready(bready), .cpu_mem_arsize(arsize),
    .cpu_mem_awsize(awsize), .cpu_mem_arburst(arburst),
    .cpu_mem_awburst(awburst), .cpu_mem_arlen(arlen),
    .cpu_mem_awlen(awlen)
  );

  function automatic logic [31:0] init_word(int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- AXI slave ----------------
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_dn, w_dn, b_pend, r_pend;
  logic [39:0] s_awaddr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_mem [4096];
  logic aw_hs, w_hs, aw_ok, w_ok;
  logic [39:0] e_awaddr;
  logic [31:0] e_wdata;
  logic [3:0]  e_wstrb;

  assign awready  = awvalid && (aw_cnt >= aw_lat);
  assign wready   = wvalid && (w_cnt >= w_lat);
  assign arready  = arvalid && (ar_cnt >= ar_lat);
  assign bvalid   = b_pend && (b_cnt >= b_lat);
  assign rvalid   = r_pend && (r_cnt >= r_lat);
  assign rdata    = s_rdata;
  assign rlast    = rvalid;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign aw_ok    = aw_dn || aw_hs;
  assign w_ok     = w_dn || w_hs;
  assign e_awaddr = aw_hs ? awaddr : s_awaddr;
  assign e_wdata  = w_hs ? wdata : s_wdata;
  assign e_wstrb  = w_hs ? wstrb : s_wstrb;

  always @(posedge cpu_clk) begin
    if (cpu_reset) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_dn <= 1'b0; w_dn <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
      for (int i = 0; i < 4096; i++) s_mem[i] <= init_word(i);
    end else begin
      if (awvalid) aw_cnt <= awready ? 0 : aw_cnt + 1;
      if (wvalid) w_cnt <= wready ? 0 : w_cnt + 1;
      if (aw_hs) begin aw_dn <= 1'b1; s_awaddr <= awaddr; end
      if (w_hs) begin w_dn <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
      if (aw_ok && w_ok) begin
        for (int b = 0; b < 4; b++)
          if (e_wstrb[b])
            s_mem[e_awaddr[13:2]][8*b +: 8] <= e_wdata[8*b +: 8];
        aw_dn <= 1'b0; w_dn <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
      end
      if (b_pend) begin
        if (bvalid && bready) b_pend <= 1'b0;
        else b_cnt <= b_cnt + 1;
      end
      if (arvalid) ar_cnt <= arready ? 0 : ar_cnt + 1;
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_cnt <= 0;
        s_rdata <= s_mem[araddr[13:2]];
      end
      if (r_pend) begin
        if (rvalid && rready) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- reference memory ----------------
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    int unsigned w = a >> 2;
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  task automatic ref_wr(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    logic [31:0] v = ref_rd(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[a >> 2] = v;
  endtask

  // ---------------- CPU driver with observations ----------------
  logic        o_acc_rdy, o_unstable, o_wlast_bad, o_b_early, o_aw_hs;
  int          o_cycles, o_aw_cyc, o_w_cyc, o_ar_cyc, o_b_first;
  int          o_rr_first, o_rdv_first, o_rdv_cyc;
  logic [39:0] o_awaddr, o_araddr;
  logic [31:0] o_wdata, o_rdata;
  logic [3:0]  o_wstrb;

  task automatic do_txn(input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int rdl);
    int seen = 0;
    o_unstable = 0; o_wlast_bad = 0; o_b_early = 0; o_aw_hs = 0;
    o_aw_cyc = 0; o_w_cyc = 0; o_ar_cyc = 0; o_b_first = -1;
    o_rr_first = -1; o_rdv_first = -1; o_rdv_cyc = 0; o_cycles = 999;
    @(negedge cpu_clk);
    MemWrite = wr; MemRead = rd; Address = a;
    Write_data = d; Write_strb = s; Read_data_Ready = 1'b0;
    o_acc_rdy = Mem_Req_Ready;
    @(posedge cpu_clk);
    #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge cpu_clk);
      if (Mem_Req_Ready) begin o_cycles = n; break; end
      if (wlast !== wvalid) o_wlast_bad = 1;
      if (awvalid) begin
        if (o_aw_cyc == 0) o_awaddr = awaddr;
        else if (awaddr !== o_awaddr) o_unstable = 1;
        o_aw_cyc++;
      end
      if (wvalid) begin
        if (o_w_cyc == 0) begin o_wdata = wdata; o_wstrb = wstrb; end
        else if (wdata !== o_wdata || wstrb !== o_wstrb) o_unstable = 1;
        o_w_cyc++;
      end
      if (arvalid) begin
        if (o_ar_cyc == 0) o_araddr = araddr;
        else if (araddr !== o_araddr) o_unstable = 1;
        o_ar_cyc++;
      end
      if (bready) begin
        if (!o_aw_hs) o_b_early = 1;
        if (o_b_first < 0) o_b_first = n;
      end
      if (rready && o_rr_first < 0) o_rr_first = n;
      if (Read_data_Valid) begin
        if (o_rdv_first < 0) begin o_rdv_first = n; o_rdata = Read_data; end
        else if (Read_data !== o_rdata) o_unstable = 1;
        o_rdv_cyc++;
        Read_data_Ready = (seen >= rdl);
        seen++;
      end
      if (awvalid && awready) o_aw_hs = 1;
    end
    Read_data_Ready = 1'b0;
  endtask

  task automatic set_lat(int aw, int w, int b, int ar, int r);
    aw_lat = aw; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    cpu_reset = 1'b1; MemWrite = 0; MemRead = 0; Address = '0;
    Write_data = '0; Write_strb = '0; Read_data_Ready = 0;
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    checks++;
    if (Mem_Req_Ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", Mem_Req_Ready);
    end
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, Read_data_Valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_valids: got %b expected 000000",
               {awvalid, wvalid, bready, arvalid, rready, Read_data_Valid});
    end
    checks++;
    if ({Read_data, awaddr, araddr, wdata, wstrb} !== '0) begin
      failures++;
      $display("FAIL reset_data: rd=%h aw=%h ar=%h wd=%h ws=%h expected 0",
               Read_data, awaddr, araddr, wdata, wstrb);
    end
    checks++;
    if ({arsize, awsize, arburst, awburst, arlen, awlen} !==
        {3'b010, 3'b010, 2'b01, 2'b01, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL axi_consts: got %h %h %h %h %h %h", arsize, awsize,
               arburst, awburst, arlen, awlen);
    end
    cpu_reset = 1'b0;
    ref_mem.delete();
  endtask

  task automatic test_write_basic;
    set_lat(0, 0, 0, 0, 0);
    do_txn(1, 0, 32'h0000_1004, 32'h1234_5678, 4'hF, 0);
    ref_wr(32'h0000_1004, 32'h1234_5678, 4'hF);
    checks++;
    if (o_awaddr !== 40'h00_0000_1004) begin
      failures++;
      $display("FAIL wr_awaddr: got %h expected 0000001004", o_awaddr);
    end
    checks++;
    if (o_wdata !== 32'h1234_5678 || o_wstrb !== 4'hF) begin
      failures++;
      $display("FAIL wr_wdata: got %h/%h expected 12345678/f", o_wdata, o_wstrb);
    end
    checks++;
    if (o_wlast_bad !== 1'b0 || o_w_cyc != 1) begin
      failures++;
      $display("FAIL wr_wlast: bad=%b wcyc=%0d expected 0/1", o_wlast_bad, o_w_cyc);
    end
    checks++;
    if (o_cycles != 3 || o_b_first != 2) begin
      failures++;
      $display("FAIL wr_latency: got %0d bready@%0d expected 3 bready@2",
               o_cycles, o_b_first);
    end
  endtask

  task automatic test_read_basic;
    set_lat(0, 0, 0, 0, 0);
    do_txn(1, 0, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 0);
    ref_wr(32'h0000_2000, 32'hDEAD_BEEF, 4'hF);
    do_txn(0, 1, 32'h0000_2002, 32'h0, 4'h0, 0);
    checks++;
    if (o_araddr !== 40'h00_0000_2000) begin
      failures++;
      $display("FAIL rd_araddr: got %h expected 0000002000", o_araddr);
    end
    checks++;
    if (o_rdata !== ref_rd(32'h2000) || o_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd_data: got %h expected deadbeef", o_rdata);
    end
    checks++;
    if (o_rr_first != 2 || o_rdv_first != 3 || o_cycles != 4) begin
      failures++;
      $display("FAIL rd_latency: rr@%0d rdv@%0d ready@%0d expected 2/3/4",
               o_rr_first, o_rdv_first, o_cycles);
    end
  endtask

  task automatic test_write_aw_delay;
    set_lat(4, 0, 0, 0, 0);
    do_txn(1, 0, 32'h0000_0040, 32'hA5A5_0F0F, 4'h5, 0);
    ref_wr(32'h0000_0040, 32'hA5A5_0F0F, 4'h5);
    checks++;
    if (o_aw_cyc != 5 || o_w_cyc != 1) begin
      failures++;
      $display("FAIL awdly_valids: aw=%0d w=%0d expected 5/1", o_aw_cyc, o_w_cyc);
    end
    checks++;
    if (o_b_early !== 1'b0 || o_b_first != 6) begin
      failures++;
      $display("FAIL awdly_bready: early=%b first=%0d expected 0/6",
               o_b_early, o_b_first);
    end
    checks++;
    if (o_cycles != 7 || o_unstable !== 1'b0) begin
      failures++;
      $display("FAIL awdly_latency: got %0d unstable=%b expected 7/0",
               o_cycles, o_unstable);
    end
  endtask

  task automatic test_read_hold;
    set_lat(0, 0, 0, 0, 0);
    do_txn(0, 1, 32'h0000_0040, 32'h0, 4'h0, 6);
    checks++;
    if (o_rdv_cyc != 7 || o_unstable !== 1'b0) begin
      failures++;
      $display("FAIL hold_valid: cyc=%0d unstable=%b expected 7/0",
               o_rdv_cyc, o_unstable);
    end
    checks++;
    if (o_rdata !== ref_rd(32'h40)) begin
      failures++;
      $display("FAIL hold_data: got %h expected %h", o_rdata, ref_rd(32'h40));
    end
    checks++;
    if (o_cycles != 10) begin
      failures++;
      $display("FAIL hold_latency: got %0d expected 10", o_cycles);
    end
  endtask

  task automatic test_reset_mid;
    logic got = 0;
    logic stale = 0;
    set_lat(0, 0, 0, 0, 10);
    @(negedge cpu_clk);
    MemRead = 1'b1; Address = 32'h0000_0080;
    @(posedge cpu_clk);
    #1;
    MemRead = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge cpu_clk);
      if (rready) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL mid_reach_rr: rready got 0 expected 1");
    end
    cpu_reset = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_reset = 1'b0;
    ref_mem.delete();
    checks++;
    if ({rready, Read_data_Valid, arvalid, awvalid, wvalid, bready} !== 6'b0
        || Mem_Req_Ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_state: vals=%b ready=%b expected 000000/1",
               {rready, Read_data_Valid, arvalid, awvalid, wvalid, bready},
               Mem_Req_Ready);
    end
    repeat (12) begin
      @(negedge cpu_clk);
      if (Read_data_Valid !== 1'b0 || Mem_Req_Ready !== 1'b1) stale = 1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL mid_stale: got stale activity expected none");
    end
    set_lat(0, 0, 0, 0, 0);
    do_txn(0, 1, 32'h0000_0084, 32'h0, 4'h0, 0);
    checks++;
    if (o_rdata !== ref_rd(32'h84) || o_cycles != 4) begin
      failures++;
      $display("FAIL mid_next_read: got %h/%0d expected %h/4",
               o_rdata, o_cycles, ref_rd(32'h84));
    end
  endtask

  task automatic test_both;
    set_lat(1, 0, 1, 0, 0);
    do_txn(1, 1, 32'h0000_00C0, 32'hCAFE_F00D, 4'hC, 0);
    ref_wr(32'h0000_00C0, 32'hCAFE_F00D, 4'hC);
    checks++;
    if (o_ar_cyc != 0 || o_aw_cyc != 2 || o_b_first < 0) begin
      failures++;
      $display("FAIL both_seq: ar=%0d aw=%0d b@%0d expected 0/2/>=0",
               o_ar_cyc, o_aw_cyc, o_b_first);
    end
    set_lat(0, 0, 0, 0, 0);
    do_txn(0, 1, 32'h0000_00C0, 32'h0, 4'h0, 0);
    checks++;
    if (o_rdata !== ref_rd(32'hC0)) begin
      failures++;
      $display("FAIL both_data: got %h expected %h", o_rdata, ref_rd(32'hC0));
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    logic r1, r2;
    set_lat(0, 0, 0, 0, 0);
    do_txn(1, 0, 32'h0000_0010, 32'h1111_2222, 4'h3, 0);
    c1 = o_cycles; r1 = o_acc_rdy;
    ref_wr(32'h0000_0010, 32'h1111_2222, 4'h3);
    do_txn(1, 0, 32'h0000_0010, 32'h3333_4444, 4'h8, 0);
    c2 = o_cycles; r2 = o_acc_rdy;
    ref_wr(32'h0000_0010, 32'h3333_4444, 4'h8);
    checks++;
    if (c1 != 3 || c2 != 3 || r1 !== 1'b1 || r2 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_latency: got %0d/%0d rdy %b/%b expected 3/3 1/1",
               c1, c2, r1, r2);
    end
    do_txn(0, 1, 32'h0000_0013, 32'h0, 4'h0, 0);
    checks++;
    if (o_rdata !== ref_rd(32'h10) || o_acc_rdy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_data: got %h expected %h", o_rdata, ref_rd(32'h10));
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int aw = $urandom_range(0, 3), w = $urandom_range(0, 3);
      int b = $urandom_range(0, 3), ar = $urandom_range(0, 3);
      int r = $urandom_range(0, 3), h = $urandom_range(0, 3);
      logic [31:0] a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
      logic [31:0] d = $urandom;
      logic [3:0] s = 4'($urandom);
      int exp;
      set_lat(aw, w, b, ar, r);
      if ($urandom_range(0, 1) == 1) begin
        do_txn(1, 0, a, d, s, 0);
        ref_wr(a, d, s);
        exp = 3 + (aw > w ? aw : w) + b;
        checks++;
        if (o_cycles != exp || o_awaddr !== {8'h0, a[31:2], 2'b00} ||
            o_wdata !== d || o_wstrb !== s || o_unstable !== 1'b0) begin
          failures++;
          $display("FAIL rnd_write[%0d]: cyc=%0d aw=%h wd=%h ws=%h expected %0d/%h/%h/%h",
                   i, o_cycles, o_awaddr, o_wdata, o_wstrb, exp,
                   {8'h0, a[31:2], 2'b00}, d, s);
        end
      end else begin
        do_txn(0, 1, a, d, s, h);
        exp = 4 + ar + r + h;
        checks++;
        if (o_cycles != exp || o_rdata !== ref_rd(a) ||
            o_rdv_cyc != h + 1 || o_unstable !== 1'b0) begin
          failures++;
          $display("FAIL rnd_read[%0d]: cyc=%0d data=%h rdv=%0d expected %0d/%h/%0d",
                   i, o_cycles, o_rdata, o_rdv_cyc, exp, ref_rd(a), h + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_aw_delay();
    test_read_hold();
    test_reset_mid();
    test_both();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
